// File: rtl/cpu_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared types for the CPU control path:
//   BUS_W          - width of the shared CPU data bus (32).
//   fetch_state_t  - states of the instruction-fetch sequencer.
//   ctrl_word_t    - the nine fetch-phase control strobes.
//   decode_state() - Moore output decode: state -> fetch strobes.
// ----------------------------------------------------------------------------
package cpu_ctrl_pkg;

  localparam int BUS_W = 32;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    T0       = 3'd1,
    T1       = 3'd2,
    WAIT_MEM = 3'd3,
    T2       = 3'd4,
    EXEC     = 3'd5,
    ERR      = 3'd6
  } fetch_state_t;

  typedef struct packed {
    logic pc_out;
    logic pc_in;
    logic ma_in;
    logic inc4;
    logic c_in;
    logic c_out;
    logic read;
    logic md_out;
    logic ir_in;
  } ctrl_word_t;

  // Each state enables at most one of pc_out / c_out / md_out, so the bus
  // never has two drivers. EXEC, IDLE and ERR leave every strobe low.
  function automatic ctrl_word_t decode_state(input fetch_state_t s);
    ctrl_word_t c;
    c = '0;
    case (s)
      T0: begin
        // PC onto bus: MAR captures it while the ALU forms PC+4 into C.
        c.pc_out = 1'b1;
        c.ma_in  = 1'b1;
        c.inc4   = 1'b1;
        c.c_in   = 1'b1;
      end
      T1: begin
        // C (PC+4) back into PC while the memory read is launched.
        c.c_out = 1'b1;
        c.pc_in = 1'b1;
        c.read  = 1'b1;
      end
      WAIT_MEM: c.read = 1'b1;
      T2: begin
        c.md_out = 1'b1;
        c.ir_in  = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/fetch_seq.sv
// ----------------------------------------------------------------------------
// fetch_seq
// Moore FSM sequencing the instruction-fetch microsteps on the shared CPU bus,
// then handing the bus to the execute controller until exec_done.
//
// Parameters:
//   MEM_TIMEOUT - max WAIT_MEM cycles before the sticky error state (0 = none)
//   TW          - wait counter width, 2^TW > MEM_TIMEOUT
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous reset, active-low
//   start      in   begin fetching (sampled only in IDLE)
//   halt       in   on exec_done: 1 = return to IDLE, 0 = fetch again
//   mem_done   in   read data valid in MDR (sampled in T1 / WAIT_MEM)
//   exec_done  in   execute phase finished (sampled in EXEC)
//   PCout, PCin, MAin, INC4, Cin, Cout, Read, MDout, IRin
//              out  fetch datapath strobes
//   exec_en    out  execute controller owns the bus
//   busy       out  sequencer active (not IDLE, not ERR)
//   err        out  memory timeout, sticky until reset
//   fetch_cnt  out  [31:0] completed fetches (only with FETCH_SEQ_CNT_EN)
//
// Optional feature macro: FETCH_SEQ_CNT_EN adds the fetch_cnt counter/port.
// ----------------------------------------------------------------------------
module fetch_seq
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int TW          = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic halt,
  input  logic mem_done,
  input  logic exec_done,
  output logic PCout,
  output logic PCin,
  output logic MAin,
  output logic INC4,
  output logic Cin,
  output logic Cout,
  output logic Read,
  output logic MDout,
  output logic IRin,
  output logic exec_en,
  output logic busy,
  output logic err
`ifdef FETCH_SEQ_CNT_EN
  ,
  output logic [BUS_W-1:0] fetch_cnt
`endif
);

  localparam bit            TIMEOUT_ON  = (MEM_TIMEOUT != 0);
  localparam logic [TW-1:0] TIMEOUT_CNT = TW'(MEM_TIMEOUT);
  localparam logic [TW-1:0] WAIT_MAX    = '1;

  fetch_state_t  state_q, state_d;
  logic [TW-1:0] wait_cnt_q, wait_cnt_d;
  ctrl_word_t    ctrl;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      IDLE: if (start) state_d = T0;
      T0:   state_d = T1;
      T1: begin
        if (mem_done) begin
          state_d = T2;
        end else begin
          state_d    = WAIT_MEM;
          wait_cnt_d = TW'(1);
        end
      end
      WAIT_MEM: begin
        // wait_cnt counts WAIT_MEM cycles already spent, so the timeout
        // fires after exactly MEM_TIMEOUT of them.
        if (mem_done) begin
          state_d    = T2;
          wait_cnt_d = '0;
        end else if (TIMEOUT_ON && (wait_cnt_q == TIMEOUT_CNT)) begin
          state_d = ERR;
        end else if (wait_cnt_q != WAIT_MAX) begin
          wait_cnt_d = wait_cnt_q + TW'(1);
        end
      end
      T2:   state_d = EXEC;
      EXEC: if (exec_done) state_d = halt ? IDLE : T0;
      ERR:  state_d = ERR;
      default: begin
        state_d    = IDLE;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Outputs depend only on state_q: no combinational input-to-output path.
  assign ctrl    = decode_state(state_q);
  assign PCout   = ctrl.pc_out;
  assign PCin    = ctrl.pc_in;
  assign MAin    = ctrl.ma_in;
  assign INC4    = ctrl.inc4;
  assign Cin     = ctrl.c_in;
  assign Cout    = ctrl.c_out;
  assign Read    = ctrl.read;
  assign MDout   = ctrl.md_out;
  assign IRin    = ctrl.ir_in;
  assign exec_en = (state_q == EXEC);
  assign err     = (state_q == ERR);
  // ERR reports through err alone; every other output, busy included, is low.
  assign busy    = (state_q != IDLE) && (state_q != ERR);

`ifdef FETCH_SEQ_CNT_EN
  logic [BUS_W-1:0] fetch_cnt_q, fetch_cnt_d;

  // One T2 cycle per completed fetch; natural wrap at 2^32.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    if (state_q == T2) fetch_cnt_d = fetch_cnt_q + BUS_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) fetch_cnt_q <= '0;
    else      fetch_cnt_q <= fetch_cnt_d;
  end

  assign fetch_cnt = fetch_cnt_q;
`endif

endmodule
